// File: rtl/mmio_test_monitor.sv
// Memory-mapped test monitor. It takes the program's verdict, buffers its console bytes and runs a watchdog.
// Define MMIO_CYCLE_CNT_EN to add a free-running cycle counter, readable at offset 0xC.
module mmio_test_monitor #(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR      = 32'hFFFF_0000,
    parameter int                    FIFO_DEPTH     = 8,
    parameter int                    TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_we,
    input  logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mmio_hit,
    output logic [7:0]            char_data,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  done,
    output logic                  pass,
    output logic [DATA_WIDTH-2:0] fail_code,
    output logic                  timeout
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WD_W-1:0]       r_wd_cnt;
    logic [DATA_WIDTH-2:0] r_fail_code;

    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ovf;

    logic [3:0]            w_off;
    logic                  w_wr_tohost;
    logic                  w_wr_console;
    logic                  w_verdict_fail;
    logic                  w_wd_expire;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_cycle;
    logic [DATA_WIDTH-1:0] w_reg;

    assign mmio_hit       = (mem_addr[DATA_WIDTH-1:4] == BASE_ADDR[DATA_WIDTH-1:4]);
    assign w_off          = mem_addr[3:0];
    assign w_wr_tohost    = mem_we & mmio_hit & (w_off == 4'h0);
    assign w_wr_console   = mem_we & mmio_hit & (w_off == 4'h4);
    assign w_verdict_fail = |mem_wdata[DATA_WIDTH-1:1];
    assign w_wd_expire    = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A verdict written on the expiry edge takes priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_RUN) begin
            if (w_wr_tohost && (mem_wdata == DATA_WIDTH'(1))) begin
                w_state_nxt = ST_PASS;
            end else if (w_wr_tohost && w_verdict_fail) begin
                w_state_nxt = ST_FAIL;
            end else if (w_wd_expire) begin
                w_state_nxt = ST_TIMEOUT;
            end
        end
    end

    always_comb begin
        done    = (r_state != ST_RUN);
        pass    = (r_state == ST_PASS);
        timeout = (r_state == ST_TIMEOUT);
    end

    assign fail_code = r_fail_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt    <= '0;
            r_fail_code <= '0;
        end else if (r_state == ST_RUN) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
            if (w_wr_tohost && w_verdict_fail) begin
                r_fail_code <= mem_wdata[DATA_WIDTH-1:1];
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign char_valid = (r_count != '0);
    assign w_pop      = char_valid & char_ready;
    assign w_push     = w_wr_console & (~w_full | w_pop);
    assign w_drop     = w_wr_console & w_full & ~w_pop;
    assign char_data  = char_valid ? r_mem[r_rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef MMIO_CYCLE_CNT_EN
    logic [DATA_WIDTH-1:0] r_cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + DATA_WIDTH'(1);
        end
    end

    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    always_comb begin
        w_status       = '0;
        w_status[0]    = done;
        w_status[1]    = pass;
        w_status[2]    = timeout;
        w_status[3]    = r_ovf;
        w_status[15:8] = 8'(r_count);
    end

    always_comb begin
        w_reg = '0;
        case (w_off)
            4'h8:    w_reg = w_status;
            4'hC:    w_reg = w_cycle;
            default: w_reg = '0;
        endcase
    end

    assign mem_rdata = (mem_re & mmio_hit) ? w_reg : '0;

endmodule

// File: doc/mmio_test_monitor.md
Name: mmio_test_monitor

Overview:
- Memory-mapped responder on the RISC_V core's data-memory bus; the core-side counterpart of the bench that drives clk/rst.
- Programs write a result word (pass/fail) and console characters.
- Block buffers characters into a FIFO drained over a valid/ready byte stream, latches the final verdict, and runs a watchdog so a hung program still terminates the run.
- Sits beside data memory; top level muxes its read data using mmio_hit.

Parameters:
- DATA_WIDTH, 32, bus data/address width.
- BASE_ADDR, 32'hFFFF_0000, base of 16-byte register window.
- FIFO_DEPTH, 8, console FIFO entries; power of two, >=2.
- TIMEOUT_CYCLES, 100000, watchdog limit in clk cycles after reset release.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_addr  in  DATA_WIDTH  byte address from core
- mem_wdata  in  DATA_WIDTH  store data
- mem_we  in  1  store strobe, sampled at rising edge
- mem_re  in  1  load strobe
- mem_rdata  out  DATA_WIDTH  load data, combinational
- mmio_hit  out  1  mem_addr[31:4]==BASE_ADDR[31:4], combinational
- char_data  out  8  FIFO head byte
- char_valid  out  1  FIFO non-empty
- char_ready  in  1  sink accepts byte when valid&ready at rising edge
- done  out  1  verdict latched
- pass  out  1  verdict is pass
- fail_code  out  DATA_WIDTH-1  fail code
- timeout  out  1  watchdog expired

Behaviour:
- Reset (async, rst=1): all outputs 0; FIFO empty; overflow sticky=0; watchdog/cycle counters=0; FSM=RUN.
- Registers (offset = mem_addr[3:0], word aligned; unaligned offsets unmapped):
  - 0x0 TOHOST (write only; reads 0).
  - 0x4 CONSOLE (write only; pushes mem_wdata[7:0]; reads 0).
  - 0x8 STATUS (read only): bit0 done, bit1 pass, bit2 timeout, bit3 overflow, bits[15:8] FIFO count, other bits 0.
  - 0xC CYCLE (read only, see Optional Feature).
- mem_rdata = register value when mem_re & mmio_hit, else 0. Writes take effect when mem_we & mmio_hit at a rising edge; writes to read-only offsets ignored.
- FSM states RUN, PASS, FAIL, TIMEOUT:
  - RUN -> PASS on TOHOST write of 1.
  - RUN -> FAIL on TOHOST write of any value >1; fail_code <= wdata[31:1].
  - TOHOST write of 0 ignored.
  - RUN -> TIMEOUT when watchdog count reaches TIMEOUT_CYCLES-1 with no verdict.
  - A same-cycle TOHOST write wins over timeout.
  - PASS/FAIL/TIMEOUT are terminal until reset; further TOHOST writes ignored.
- done/pass/timeout are registered: assert the cycle after the deciding edge.
- Watchdog increments every cycle in RUN only; it freezes on leaving RUN.
- FIFO:
  - Push on CONSOLE write; pop on char_valid&char_ready.
  - Push when full without same-cycle pop: dropped, overflow sticky set.
  - Push when full with same-cycle pop: accepted, count unchanged.
  - Push and pop when empty: push accepted, no pop, count=1.
  - Pointers wrap modulo FIFO_DEPTH.
- Console FIFO keeps operating in all FSM states.
- Reset asserted mid-run clears everything immediately, including buffered bytes.

Optional Feature:
- Macro MMIO_CYCLE_CNT_EN.
- Defined: a free-running DATA_WIDTH cycle counter, cleared by reset, increments every cycle and wraps. It is readable at offset 0xC and continues counting after done.
- Undefined: counter not instantiated; offset 0xC reads 0.

Test Plan:
- Reset: assert rst mid-stream with FIFO holding 3 bytes -> immediately char_valid=0, done=0, STATUS read 0x0000_0000.
- Console: char_ready=0, store 0x41 then 0x42 to BASE+4 -> char_valid=1, char_data=0x41, STATUS[15:8]=2. Then char_ready=1 -> 0x41 then 0x42 transferred on consecutive edges, then char_valid=0.
- Overflow: char_ready=0, 9 stores to BASE+4 (DEPTH 8) -> STATUS=0x0000_0808 (count 8, overflow), 9th byte absent from drain. Push on a full FIFO with a same-cycle pop is accepted.
- Pass: store 1 to BASE+0 -> next cycle done=1, pass=1. A later store of 5 leaves fail_code=0, pass=1.
- Fail: store 7 to BASE+0 -> done=1, pass=0, fail_code=3, STATUS bit1=0.
- Watchdog: TIMEOUT_CYCLES=20, no TOHOST writes -> timeout=1, done=1, pass=0 exactly 20 cycles after rst deassert. A TOHOST write of 1 on the expiry cycle instead yields pass=1, timeout=0.
